vram_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM between three requesters: VGA scan-out reader (display), CPU/drawing port (read/write), and a background screen-clear engine.
- Display has strict priority so scan-out latency is fixed. CPU is served in idle RAM cycles. Clear uses leftover cycles.
- Sits between the VGA timing/pixel pipeline and the VRAM macro inside top_vga.

---
 rtl/vram_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_vram_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display scan-out has strict priority, CPU gets
// idle cycles, and a background clear engine fills leftover cycles.
module vram_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 12,
  parameter int DEPTH  = 19200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_ACK = 3'd1,
    RD1    = 3'd2,
    RD2    = 3'd3,
    RD_ACK = 3'd4
  } cpu_state_e;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

  cpu_state_e        state_q, state_d;
  logic              cpu_grant_s, clr_accept_s, clr_issue_s, clr_last_s;
  logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              disp_p1_q, disp_p1_d, disp_p2_q, disp_p2_d;
  logic              disp_valid_q, disp_valid_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              clr_busy_q, clr_busy_d, clr_done_q, clr_done_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] clr_color_q, clr_color_d;

  // Who owns the RAM in this cycle
  always_comb begin
    cpu_grant_s  = (state_q == IDLE) && cpu_req && !disp_req;
    clr_issue_s  = clr_busy_q && !disp_req && !cpu_grant_s;
    clr_last_s   = clr_issue_s && (clr_cnt_q == CLR_LAST);
    clr_accept_s = clr_start && !clr_busy_q;
  end

  // RAM command for the next cycle; address and data hold when idle
  always_comb begin
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (disp_req) begin
      ram_en_d   = 1'b1;
      ram_addr_d = disp_addr;
    end else if (cpu_grant_s) begin
      ram_en_d   = 1'b1;
      ram_we_d   = cpu_we;
      ram_addr_d = cpu_addr;
      if (cpu_we) begin
        ram_wdata_d = cpu_wdata;
      end else begin
        ram_wdata_d = ram_wdata_q;
      end
    end else if (clr_issue_s) begin
      ram_en_d    = 1'b1;
      ram_we_d    = 1'b1;
      ram_addr_d  = clr_cnt_q;
      ram_wdata_d = clr_color_q;
    end else begin
      ram_en_d = 1'b0;
    end
  end

  // Display read tag follows the RAM latency so only display reads reach disp_*
  always_comb begin
    disp_p1_d    = disp_req;
    disp_p2_d    = disp_p1_q;
    disp_valid_d = disp_p2_q;
    if (disp_p2_q) begin
      disp_data_d = ram_rdata;
    end else begin
      disp_data_d = disp_data_q;
    end
  end

  // CPU handshake FSM; no re-grant until back in IDLE
  always_comb begin
    state_d     = state_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_grant_s) begin
          state_d   = cpu_we ? WR_ACK : RD1;
          cpu_ack_d = cpu_we;
        end else begin
          state_d = IDLE;
        end
      end
      WR_ACK: state_d = IDLE;
      RD1:    state_d = RD2;
      RD2: begin
        state_d     = RD_ACK;
        cpu_ack_d   = 1'b1;
        cpu_rdata_d = ram_rdata;
      end
      RD_ACK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Clear engine walks 0..DEPTH-1 using cycles nobody else wants
  always_comb begin
    clr_busy_d  = clr_busy_q;
    clr_cnt_d   = clr_cnt_q;
    clr_color_d = clr_color_q;
    clr_done_d  = 1'b0;
    if (clr_accept_s) begin
      clr_busy_d  = 1'b1;
      clr_cnt_d   = {ADDR_W{1'b0}};
      clr_color_d = clr_color;
    end else if (clr_last_s) begin
      clr_busy_d = 1'b0;
      clr_cnt_d  = {ADDR_W{1'b0}};
      clr_done_d = 1'b1;
    end else if (clr_issue_s) begin
      clr_cnt_d = clr_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      clr_cnt_d = clr_cnt_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= {ADDR_W{1'b0}};
      ram_wdata_q  <= {DATA_W{1'b0}};
      disp_p1_q    <= 1'b0;
      disp_p2_q    <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= {DATA_W{1'b0}};
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= {DATA_W{1'b0}};
      clr_busy_q   <= 1'b0;
      clr_done_q   <= 1'b0;
      clr_cnt_q    <= {ADDR_W{1'b0}};
      clr_color_q  <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      disp_p1_q    <= disp_p1_d;
      disp_p2_q    <= disp_p2_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      clr_busy_q   <= clr_busy_d;
      clr_done_q   <= clr_done_d;
      clr_cnt_q    <= clr_cnt_d;
      clr_color_q  <= clr_color_d;
    end
  end

  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign clr_busy   = clr_busy_q;
  assign clr_done   = clr_done_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: behavioural RAM, reference memory image and
// due-cycle scoreboards for display data and CPU acknowledges.
module tb_vram_arbiter;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 12;
  localparam int DEPTH  = 19200;
  localparam int MEM_N  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              clr_start;
  logic [DATA_W-1:0] clr_color;
  logic              clr_busy, clr_done;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .clr_start(clr_start), .clr_color(clr_color),
    .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
    bit                chk_data;
  } exp_t;

  exp_t              disp_q[$];
  exp_t              cpu_q[$];
  logic [DATA_W-1:0] ram [0:MEM_N-1];
  logic [DATA_W-1:0] ref_mem [0:MEM_N-1];
  int                total = 0;
  int                bad = 0;
  int                pcyc = 0;
  int                done_cnt = 0;

  // Synchronous single-port RAM: read data appears the cycle after ram_en
  initial begin
    ram_rdata = '0;
    for (int a = 0; a < MEM_N; a++) ram[a] = DATA_W'(a + 256);
    forever begin
      @(posedge clk);
      if (ram_en) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        else        ram_rdata     <= ram[ram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ram"}, 32'({ram_en, ram_we, ram_addr, ram_wdata}), 32'h0);
    chk({tag, "_out"}, 32'({disp_valid, disp_data, cpu_ack, cpu_rdata, clr_busy, clr_done}), 32'h0);
  endtask

  // Advance one clock, then compare outputs against whatever is due now
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    pcyc++;
    if (clr_done === 1'b1) done_cnt++;
    if (disp_q.size() > 0 && disp_q[0].due == pcyc) begin
      e = disp_q.pop_front();
      chk("disp_valid", 32'(disp_valid), 32'h1);
      chk("disp_data", 32'(disp_data), 32'(e.data));
    end else begin
      chk("disp_quiet", 32'(disp_valid), 32'h0);
    end
    if (cpu_q.size() > 0 && cpu_q[0].due == pcyc) begin
      e = cpu_q.pop_front();
      chk("cpu_ack", 32'(cpu_ack), 32'h1);
      if (e.chk_data) chk("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
    end else begin
      chk("cpu_ack_quiet", 32'(cpu_ack), 32'h0);
    end
  endtask

  task automatic cpu_wait_ack();
    for (int k = 0; k < 64 && cpu_ack !== 1'b1; k++) tick();
    chk("cpu_ack_seen", 32'(cpu_ack), 32'h1);
    cpu_req = 1'b0;
  endtask

  task automatic mem_cmp(input string tag);
    int mism = 0;
    for (int a = 0; a < MEM_N; a++) if (ram[a] !== ref_mem[a]) mism++;
    chk(tag, 32'(mism), 32'h0);
  endtask

  task automatic wait_clear(input string tag);
    for (int k = 0; k < 2 * DEPTH && clr_busy === 1'b1; k++) tick();
    chk(tag, 32'(clr_busy), 32'h0);
  endtask

  initial begin
    int busy_cnt;
    int d0;
    rst_n = 1'b0; disp_req = 1'b0; disp_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    clr_start = 1'b0; clr_color = '0;
    for (int a = 0; a < MEM_N; a++) ref_mem[a] = DATA_W'(a + 256);
    #3;
    chk_zero("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Display burst 0..7, three-cycle latency
    for (int i = 0; i < 8; i++) begin
      disp_req = 1'b1; disp_addr = ADDR_W'(i);
      disp_q.push_back('{pcyc + 3, ref_mem[i], 1'b1});
      tick();
    end
    disp_req = 1'b0;
    repeat (4) tick();

    // CPU write then read back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0123; cpu_wdata = 12'hABC;
    cpu_q.push_back('{pcyc + 1, 12'h000, 1'b0});
    tick();
    chk("wr_cmd", 32'({ram_en, ram_we, ram_addr, ram_wdata}), 32'({1'b1, 1'b1, 15'h0123, 12'hABC}));
    cpu_wait_ack();
    ref_mem[15'h0123] = 12'hABC;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0;
    cpu_q.push_back('{pcyc + 3, ref_mem[15'h0123], 1'b1});
    cpu_wait_ack();
    tick();

    // CPU read starved by 10 display cycles
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0123;
    for (int i = 0; i < 10; i++) begin
      disp_req = 1'b1; disp_addr = ADDR_W'(64 + i);
      disp_q.push_back('{pcyc + 3, ref_mem[64 + i], 1'b1});
      tick();
      chk("starve_we", 32'(ram_we), 32'h0);
      chk("starve_addr", 32'(ram_addr), 32'(64 + i));
    end
    disp_req = 1'b0;
    cpu_q.push_back('{pcyc + 3, 12'hABC, 1'b1});
    tick();
    chk("starve_grant_addr", 32'(ram_addr), 32'h0123);
    cpu_wait_ack();
    repeat (4) tick();

    // Plain clear with an ignored second start mid-way
    clr_color = 12'h00F; clr_start = 1'b1;
    tick();
    clr_start = 1'b0; clr_color = 12'h0F0;
    d0 = done_cnt; busy_cnt = 0;
    for (int k = 0; k < DEPTH + 100 && clr_busy === 1'b1; k++) begin
      busy_cnt++;
      clr_start = (k == 100);
      tick();
    end
    clr_start = 1'b0;
    chk("clr_busy_len", 32'(busy_cnt), 32'(DEPTH));
    chk("clr_done_edge", 32'(clr_done), 32'h1);
    tick();
    chk("clr_done_once", 32'(done_cnt - d0), 32'h1);
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = 12'h00F;
    mem_cmp("clr_mem");

    // Clear sharing with 1-in-2 display traffic and CPU writes
    clr_color = 12'h3C5; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 200; i++) begin
      disp_req = (i % 2 == 0);
      disp_addr = ADDR_W'(28672 + i);
      if (disp_req) disp_q.push_back('{pcyc + 3, ref_mem[28672 + i], 1'b1});
      cpu_req = 1'b0;
      if (i == 51 || i == 101) begin
        cpu_req = 1'b1; cpu_we = 1'b1;
        cpu_addr = (i == 51) ? 15'd5 : 15'd16000;
        cpu_wdata = (i == 51) ? 12'h777 : 12'h555;
        cpu_q.push_back('{pcyc + 1, 12'h000, 1'b0});
      end
      tick();
    end
    disp_req = 1'b0; cpu_req = 1'b0;
    wait_clear("clr2_idle");
    tick(); tick();
    chk("clr2_done_once", 32'(done_cnt - d0), 32'h1);
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = 12'h3C5;
    ref_mem[5] = 12'h777;
    mem_cmp("clr2_mem");

    // Reset in the middle of a clear and a CPU read
    clr_color = 12'h111; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (50) tick();
    chk("rst_mid_busy", 32'(clr_busy), 32'h1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h7100;
    tick();
    rst_n = 1'b0;
    #1;
    chk_zero("rst_async");
    disp_q.delete(); cpu_q.delete();
    cpu_req = 1'b0; d0 = done_cnt;
    tick(); tick();
    chk_zero("rst_hold");
    rst_n = 1'b1;
    repeat (20) tick();
    chk("rst_no_done", 32'(done_cnt - d0), 32'h0);
    chk("rst_no_busy", 32'(clr_busy), 32'h0);
    clr_color = 12'h222; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    tick();
    chk("restart_cmd", 32'({ram_en, ram_we, ram_addr, ram_wdata}), 32'({1'b1, 1'b1, 15'h0000, 12'h222}));
    wait_clear("clr3_idle");
    tick();
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = 12'h222;
    mem_cmp("clr3_mem");
    chk("sb_empty", 32'(disp_q.size() + cpu_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
